// File: rtl/pc_predict_ras.sv
// ---------------------------------------------------------------------------
// pc_predict_ras
//
// PC select and predict unit for the pipelined Y86-64 core. Each cycle it
// picks the fetch address from the predicted-PC register or from a late
// redirect (W-stage ret mismatch beats M-stage jXX mispredict). It then
// registers the next prediction from the fetched instruction. A circular
// return-address stack (RAS) supplies `ret` targets.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   f_stall           hold pred_pc and RAS (a redirect flush still happens)
//   f_valid           fetched instruction valid
//   f_icode/valC/valP fetched instruction fields
//   m_icode/cnd/valA  M-stage jXX resolution
//   w_icode/valM      W-stage ret resolution
//   w_ret_pred/tgt    prediction info carried down the pipe with the ret
//   f_pc              fetch address (combinational)
//   pred_pc           registered predicted PC
//   redirect          f_pc came from M or W this cycle
//   f_ret_pred        fetched ret is predicted from the RAS
//   f_ret_tgt         RAS top entry (0 when empty)
//   ras_count         number of valid RAS entries
//   ras_ovf           sticky: a push happened while the RAS was full
// ---------------------------------------------------------------------------
module pc_predict_ras #(
    parameter int                 ADDR_W    = 64,
    parameter int                 RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             f_stall,
    input  logic                             f_valid,
    input  logic [3:0]                       f_icode,
    input  logic [ADDR_W-1:0]                f_valC,
    input  logic [ADDR_W-1:0]                f_valP,
    input  logic [3:0]                       m_icode,
    input  logic                             m_cnd,
    input  logic [ADDR_W-1:0]                m_valA,
    input  logic [3:0]                       w_icode,
    input  logic [ADDR_W-1:0]                w_valM,
    input  logic                             w_ret_pred,
    input  logic [ADDR_W-1:0]                w_ret_tgt,
    output logic [ADDR_W-1:0]                f_pc,
    output logic [ADDR_W-1:0]                pred_pc,
    output logic                             redirect,
    output logic                             f_ret_pred,
    output logic [ADDR_W-1:0]                f_ret_tgt,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_ovf
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    localparam logic [3:0] IC_HALT = 4'h0;
    localparam logic [3:0] IC_JXX  = 4'h7;
    localparam logic [3:0] IC_CALL = 4'h8;
    localparam logic [3:0] IC_RET  = 4'h9;

    logic [ADDR_W-1:0] pred_pc_reg, pred_pc_next;
    logic [PTR_W-1:0]  top_reg, top_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              ovf_reg, ovf_next;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

    logic              w_mismatch;
    logic              m_mispred;
    logic              ras_nonempty;
    logic              is_call;
    logic              push_en;
    logic [PTR_W-1:0]  push_idx;
    logic [CNT_W-1:0]  base_count;

    // ---------------- PC select ----------------
    always_comb begin
        w_mismatch = (w_icode == IC_RET) && (!w_ret_pred || (w_valM != w_ret_tgt));
        m_mispred  = (m_icode == IC_JXX) && !m_cnd;
        redirect   = w_mismatch || m_mispred;
        // W holds the older instruction, so its redirect takes priority.
        if (w_mismatch)
            f_pc = w_valM;
        else if (m_mispred)
            f_pc = m_valA;
        else
            f_pc = pred_pc_reg;
    end

    // ---------------- RAS read side ----------------
    always_comb begin
        ras_nonempty = (count_reg != '0);
        f_ret_tgt    = ras_nonempty ? ras_mem[top_reg] : '0;
        f_ret_pred   = f_valid && (f_icode == IC_RET) && ras_nonempty;
        is_call      = f_valid && (f_icode == IC_CALL);
    end

    // ---------------- next prediction ----------------
    always_comb begin
        pred_pc_next = f_valP;
        if (!f_valid || (f_icode == IC_HALT))
            pred_pc_next = f_pc;
        else if ((f_icode == IC_JXX) || (f_icode == IC_CALL))
            pred_pc_next = f_valC;
        else if (f_icode == IC_RET)
            pred_pc_next = ras_nonempty ? f_ret_tgt : f_valP;
        if (f_stall)
            pred_pc_next = pred_pc_reg;
    end

    // ---------------- RAS update ----------------
    // A redirect empties the stack first; the instruction fetched at the
    // redirect target then acts on the empty stack (a call leaves one entry,
    // a ret has nothing to pop). The flush is applied even under stall.
    always_comb begin
        base_count = redirect ? '0 : count_reg;
        top_next   = top_reg;
        count_next = base_count;
        ovf_next   = ovf_reg;
        push_en    = 1'b0;
        push_idx   = top_reg + PTR_W'(1);
        if (!f_stall) begin
            if (is_call) begin
                // When full, top+1 is the oldest slot, so the push overwrites it.
                push_en  = 1'b1;
                top_next = push_idx;
                if (base_count == CNT_FULL) begin
                    count_next = CNT_FULL;
                    ovf_next   = 1'b1;
                end else begin
                    count_next = base_count + CNT_W'(1);
                end
            end else if (f_ret_pred && !redirect) begin
                top_next   = top_reg - PTR_W'(1);
                count_next = count_reg - CNT_W'(1);
            end
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_pc_reg <= RESET_PC;
            top_reg     <= '0;
            count_reg   <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            pred_pc_reg <= pred_pc_next;
            top_reg     <= top_next;
            count_reg   <= count_next;
            ovf_reg     <= ovf_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++)
                ras_mem[i] <= '0;
        end else if (push_en) begin
            ras_mem[push_idx] <= f_valP;
        end
    end

    assign pred_pc   = pred_pc_reg;
    assign ras_count = count_reg;
    assign ras_ovf   = ovf_reg;

endmodule

// File: doc/pc_predict_ras.md
# pc_predict_ras

Parametrised program-counter select and predict unit for the pipelined Y86-64 core, succeeding the single-cycle SEQ PC update. It drives the fetch address each cycle from the predicted-PC register or from late redirects out of the M and W stages. It registers the next prediction from the fetched instruction. A configurable-depth return-address stack (RAS) predicts `ret` targets, so the pipeline no longer needs three `ret` bubbles on a correct prediction.

## Interface
- ADDR_W, 64, address/data width of all PC values
- RAS_DEPTH, 8, RAS entries; power of two, ≥2
- RESET_PC, 0, value loaded into pred_pc at reset
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- f_stall  in  1  fetch stall; holds pred_pc and RAS
- f_valid  in  1  fetched instruction valid (0 on imem error)
- f_icode  in  4  icode of instruction at f_pc
- f_valC  in  ADDR_W  constant word of fetched instruction
- f_valP  in  ADDR_W  fall-through address of fetched instruction
- m_icode  in  4  M-stage icode
- m_cnd  in  1  M-stage condition result
- m_valA  in  ADDR_W  M-stage valA (fall-through of jXX)
- w_icode  in  4  W-stage icode
- w_valM  in  ADDR_W  W-stage loaded value (true ret target)
- w_ret_pred  in  1  ret in W was RAS-predicted (carried from f_ret_pred)
- w_ret_tgt  in  ADDR_W  target predicted for that ret (carried from f_ret_tgt)
- f_pc  out  ADDR_W  fetch address (combinational)
- pred_pc  out  ADDR_W  registered predicted PC
- redirect  out  1  f_pc taken from M or W this cycle
- f_ret_pred  out  1  fetched ret has RAS prediction
- f_ret_tgt  out  ADDR_W  RAS top entry
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries
- ras_ovf  out  1  sticky: push occurred while full

## Operation
- icodes: 0 halt, 7 jXX, 8 call, 9 ret; all other icodes are sequential.
- Redirect sources, in priority order:
  - W mismatch: w_icode==9 and (!w_ret_pred or w_valM≠w_ret_tgt) → f_pc=w_valM. W is the older instruction and wins.
  - M mispredict: m_icode==7 and !m_cnd → f_pc=m_valA.
  - Otherwise f_pc=pred_pc and redirect=0.
- Prediction from the instruction at f_pc, loaded into pred_pc when !f_stall:
  - f_valid==0 or halt → f_pc (hold).
  - jXX → f_valC (always-taken).
  - call → f_valC, and push f_valP.
  - ret with ras_count>0 → RAS top, and pop. ret with ras_count==0 → f_valP, no pop, f_ret_pred=0.
  - other → f_valP.
- f_ret_pred = (f_icode==9) and (ras_count>0) and f_valid. f_ret_tgt = top entry whenever ras_count>0, else 0.
- RAS is circular: top pointer plus count.
  - Push when full: overwrite oldest, count stays RAS_DEPTH, set ras_ovf.
  - Pointer wraps modulo RAS_DEPTH.
- Any redirect flushes the RAS (count←0). The push/pop of the instruction fetched at the redirect target in that same cycle is applied after the flush: call → count=1, ret → empty, no pop.
- No RAS or pred_pc change when f_stall=1, even on redirect. Exception: the flush still occurs.
- Arithmetic: all PC values are ADDR_W wide, no carries beyond ADDR_W; count and pointer wrap/saturate as stated.

## Timing
- Reset (async assert, sync-to-clk deassert by the top level):
  - pred_pc=RESET_PC, ras_count=0, top pointer=0, all entries 0, ras_ovf=0.
  - Combinational outputs follow from these values and the inputs.
- f_pc, redirect, f_ret_pred, f_ret_tgt are combinational, same-cycle.
- pred_pc, RAS contents, ras_count, ras_ovf update one rising edge after the qualifying cycle.
- A call followed back-to-back by its ret: the ret sees the pushed entry in the next cycle (no bypass needed).
- Reset mid-operation: all state returns to reset values immediately; ras_ovf clears only on reset.

## Test plan
- Reset with RESET_PC=0x100 → pred_pc=f_pc=0x100, ras_count=0, ras_ovf=0; then nop with f_valP=0x101 → pred_pc=0x101 next cycle.
- call f_valC=0x200, f_valP=0x109; next ret → f_ret_pred=1, f_ret_tgt=0x109, pred_pc=0x109, ras_count 1→0.
- RAS_DEPTH=8: nine calls (valP 1..9) then nine rets → targets 9..2 predicted, ras_ovf=1, ninth ret has f_ret_pred=0 and pred_pc=its valP.
- jXX f_valC=0x300 → pred_pc=0x300; two cycles later m_icode=7, m_cnd=0, m_valA=0x20A → f_pc=0x20A, redirect=1, ras_count=0 next cycle.
- Simultaneous W ret mismatch (w_valM=0x500, w_ret_tgt=0x480) and M mispredict (m_valA=0x600) → f_pc=0x500.
- f_stall=1 with call fetched → pred_pc and ras_count unchanged. Halt fetched → pred_pc=f_pc. Assert rst_n=0 mid-sequence → outputs at reset values before the next edge.
